// File: rtl/macro_snapshot_buffer_if.sv
// Collider-side capture inputs and host GPIO read/status signals for the
// macroscopic snapshot buffer.
interface macro_snapshot_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         collider_ready;
  logic                         in_collision_state;
  logic signed [DATA_WIDTH-1:0] u_x;
  logic signed [DATA_WIDTH-1:0] u_y;
  logic signed [DATA_WIDTH-1:0] rho;
  logic        [15:0]           GPIOi;
  logic signed [15:0]           GPIOux;
  logic signed [15:0]           GPIOuy;
  logic signed [15:0]           GPIOrho;
  logic                         frame_valid;
  logic        [15:0]           frame_count;
  logic        [7:0]            drop_count;
  logic                         partial_err;

  modport master (
    output collider_ready, in_collision_state, u_x, u_y, rho, GPIOi,
    input  GPIOux, GPIOuy, GPIOrho, frame_valid, frame_count, drop_count, partial_err
  );

  modport slave (
    input  collider_ready, in_collision_state, u_x, u_y, rho, GPIOi,
    output GPIOux, GPIOuy, GPIOrho, frame_valid, frame_count, drop_count, partial_err
  );
endinterface

// File: rtl/macro_snapshot_buffer.sv
// Double-buffered snapshot of collider results (u_x, u_y, rho): one bank is
// filled per sweep while the host reads the other through a 2-cycle pipeline.
module macro_snapshot_buffer #(
  parameter int DEPTH      = 2500,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  macro_snapshot_buffer_if.slave bus
);

  localparam int WW = 3 * DATA_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam addr_t LAST = addr_t'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SWAP_PEND} state_e;

  state_e             state_q, state_d;
  logic               in_cs_q;
  addr_t              wptr_q, wptr_d;
  logic               front_sel_q, front_sel_d;
  logic               frame_valid_q, frame_valid_d;
  logic [15:0]        frame_count_q, frame_count_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic               partial_err_q, partial_err_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_ok_q, rd_ok_d;
  addr_t              rd_idx_q, rd_idx_d;
  logic signed [15:0] gux_q, gux_d;
  logic signed [15:0] guy_q, guy_d;
  logic signed [15:0] grho_q, grho_d;

  logic [WW-1:0] bank0 [DEPTH];
  logic [WW-1:0] bank1 [DEPTH];

  logic          host_tx;
  logic [14:0]   host_idx;
  logic          rise, fall, cap, complete, do_swap;
  addr_t         wbase;
  logic [WW-1:0] wdata, rd_word;

  assign host_tx  = bus.GPIOi[15];
  assign host_idx = bus.GPIOi[14:0];
  assign rise     = bus.in_collision_state & ~in_cs_q;
  assign fall     = ~bus.in_collision_state & in_cs_q;
  assign cap      = bus.collider_ready & bus.in_collision_state;
  // The rise cycle already writes cell 0, so the pointer reads as cleared there.
  assign wbase    = rise ? '0 : wptr_q;
  assign complete = cap && (wbase == LAST);
  assign wdata    = {bus.u_x, bus.u_y, bus.rho};
  assign rd_word  = front_sel_q ? bank1[rd_idx_q] : bank0[rd_idx_q];

  always_comb begin
    state_d       = state_q;
    wptr_d        = wbase;
    front_sel_d   = front_sel_q;
    frame_valid_d = frame_valid_q;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;
    partial_err_d = partial_err_q;
    do_swap       = 1'b0;

    if (cap) wptr_d = complete ? '0 : wbase + 1'b1;

    case (state_q)
      IDLE:      if (rise) state_d = CAPTURE;
      CAPTURE:   if (fall) state_d = IDLE;
      SWAP_PEND: if (!host_tx) begin
                   do_swap = 1'b1;
                   state_d = IDLE;
                 end
      default:   state_d = IDLE;
    endcase

    // A completion while already pending overwrites the unpublished frame.
    if (complete) begin
      if (state_q == SWAP_PEND) begin
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end else if (host_tx) begin
        state_d = SWAP_PEND;
      end else begin
        do_swap = 1'b1;
        state_d = IDLE;
      end
    end

    if (fall && (wptr_q != '0)) partial_err_d = 1'b1;

    if (do_swap) begin
      front_sel_d   = ~front_sel_q;
      frame_count_d = frame_count_q + 16'd1;
      frame_valid_d = 1'b1;
    end
  end

  always_comb begin
    rd_en_d  = host_tx;
    rd_idx_d = host_tx ? addr_t'(host_idx) : rd_idx_q;
    rd_ok_d  = host_tx && frame_valid_q && (32'(host_idx) < DEPTH);
    gux_d    = gux_q;
    guy_d    = guy_q;
    grho_d   = grho_q;
    if (rd_en_q) begin
      gux_d  = rd_ok_q ? 16'(signed'(rd_word[WW-1 -: DATA_WIDTH]))           : '0;
      guy_d  = rd_ok_q ? 16'(signed'(rd_word[2*DATA_WIDTH-1 -: DATA_WIDTH])) : '0;
      grho_d = rd_ok_q ? 16'(signed'(rd_word[DATA_WIDTH-1:0]))               : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      in_cs_q       <= 1'b0;
      wptr_q        <= '0;
      front_sel_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      partial_err_q <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_ok_q       <= 1'b0;
      rd_idx_q      <= '0;
      gux_q         <= '0;
      guy_q         <= '0;
      grho_q        <= '0;
    end else begin
      state_q       <= state_d;
      in_cs_q       <= bus.in_collision_state;
      wptr_q        <= wptr_d;
      front_sel_q   <= front_sel_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      partial_err_q <= partial_err_d;
      rd_en_q       <= rd_en_d;
      rd_ok_q       <= rd_ok_d;
      rd_idx_q      <= rd_idx_d;
      gux_q         <= gux_d;
      guy_q         <= guy_d;
      grho_q        <= grho_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      if (front_sel_q) bank0[wbase] <= wdata;
      else             bank1[wbase] <= wdata;
    end
  end

  assign bus.GPIOux      = gux_q;
  assign bus.GPIOuy      = guy_q;
  assign bus.GPIOrho     = grho_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_count = frame_count_q;
  assign bus.drop_count  = drop_count_q;
  assign bus.partial_err = partial_err_q;

endmodule

// File: tb/tb_macro_snapshot_buffer.sv
// Directed bench for macro_snapshot_buffer: capture sweeps, swap/pend/drop,
// partial sweeps, host read latency, out-of-range reads and mid-sweep reset.
module tb_macro_snapshot_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  macro_snapshot_buffer_if #(.DATA_WIDTH(16)) bus ();

  macro_snapshot_buffer #(
    .DEPTH(2500),
    .DATA_WIDTH(16),
    .ADDR_WIDTH(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input int ux, input int uy, input int rh);
    check({tag, ".ux"},  bus.GPIOux,  ux);
    check({tag, ".uy"},  bus.GPIOuy,  uy);
    check({tag, ".rho"}, bus.GPIOrho, rh);
  endtask

  task automatic sweep(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.in_collision_state = 1'b1;
      bus.collider_ready     = 1'b1;
      bus.u_x = 16'(base + i);
      bus.u_y = 16'(-(base + i));
      bus.rho = 16'h1000;
      tick();
    end
    bus.collider_ready = 1'b0;
  endtask

  task automatic end_sweep();
    bus.in_collision_state = 1'b0;
    bus.collider_ready     = 1'b0;
    tick();
  endtask

  task automatic read(input int idx);
    bus.GPIOi = {1'b1, 15'(idx)};
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.collider_ready     = 1'b0;
    bus.in_collision_state = 1'b0;
    bus.u_x   = '0;
    bus.u_y   = '0;
    bus.rho   = '0;
    bus.GPIOi = '0;
    tick(); tick(); tick();

    check_rd("reset", 0, 0, 0);
    check("reset.frame_valid", bus.frame_valid, 0);
    check("reset.frame_count", bus.frame_count, 0);
    check("reset.drop_count",  bus.drop_count,  0);
    check("reset.partial_err", bus.partial_err, 0);
    rst = 1'b1;
    tick();

    // Read before any frame exists
    read(5);
    check_rd("noframe_rd5", 0, 0, 0);
    check("noframe.frame_valid", bus.frame_valid, 0);
    bus.GPIOi = '0;

    // First full frame, host idle
    sweep(2500, 0);
    check("f1.frame_count", bus.frame_count, 1);
    check("f1.frame_valid", bus.frame_valid, 1);
    end_sweep();
    check("f1.partial_err", bus.partial_err, 0);

    bus.GPIOi = {1'b1, 15'd42};
    tick();
    check("rd42.latency1", bus.GPIOux, 0);
    tick();
    check_rd("rd42", 42, -42, 32'h1000);
    bus.GPIOi = {1'b0, 15'd7};
    tick(); tick();
    check("hold.ux", bus.GPIOux, 42);

    // Frame completes while host is reading: swap pends
    bus.GPIOi = {1'b1, 15'd10};
    sweep(2500, 100);
    check("pend.frame_count", bus.frame_count, 1);
    end_sweep();
    tick(); tick();
    check("pend2.frame_count", bus.frame_count, 1);
    check_rd("pend.rd10", 10, -10, 32'h1000);
    bus.GPIOi = {1'b0, 15'd10};
    tick();
    check("release.frame_count", bus.frame_count, 2);
    read(10);
    check_rd("f2.rd10", 110, -110, 32'h1000);

    // Two frames complete while pending: one dropped
    bus.GPIOi = {1'b1, 15'd3};
    sweep(2500, 200);
    end_sweep();
    sweep(2500, 300);
    end_sweep();
    check("drop.drop_count",  bus.drop_count,  1);
    check("drop.frame_count", bus.frame_count, 2);
    check_rd("drop.rd3_old", 103, -103, 32'h1000);
    bus.GPIOi = {1'b0, 15'd3};
    tick();
    check("drop.release_count", bus.frame_count, 3);
    read(3);
    check_rd("f4.rd3", 303, -303, 32'h1000);
    check("drop.partial_err", bus.partial_err, 0);
    bus.GPIOi = '0;

    // Short sweep, then a full one restarting at cell 0
    sweep(100, 9000);
    end_sweep();
    check("partial.partial_err", bus.partial_err, 1);
    check("partial.frame_count", bus.frame_count, 3);
    sweep(2500, 400);
    end_sweep();
    check("after_partial.frame_count", bus.frame_count, 4);
    read(0);
    check_rd("ap.rd0", 400, -400, 32'h1000);
    read(99);
    check_rd("ap.rd99", 499, -499, 32'h1000);
    read(2499);
    check_rd("ap.rd2499", 2899, -2899, 32'h1000);

    // Out of range index
    read(2500);
    check_rd("oor.rd2500", 0, 0, 0);
    bus.GPIOi = '0;

    // Reset in the middle of a sweep
    sweep(1000, 600);
    rst = 1'b0;
    bus.in_collision_state = 1'b0;
    bus.collider_ready     = 1'b0;
    tick();
    check_rd("midrst", 0, 0, 0);
    check("midrst.frame_valid", bus.frame_valid, 0);
    check("midrst.frame_count", bus.frame_count, 0);
    check("midrst.drop_count",  bus.drop_count,  0);
    check("midrst.partial_err", bus.partial_err, 0);
    rst = 1'b1;
    tick();
    read(5);
    check_rd("midrst.rd5", 0, 0, 0);
    bus.GPIOi = '0;
    sweep(2500, 700);
    end_sweep();
    check("post_rst.frame_count", bus.frame_count, 1);
    check("post_rst.frame_valid", bus.frame_valid, 1);
    read(1000);
    check_rd("post_rst.rd1000", 1700, -1700, 32'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
